// File: rtl/fir_cap_pkg.sv
// Shared types and defaults for the FIR output capture block.
// FIR_CAP_TRIG_EN (used by fir_capture) selects the level trigger; the default build has no trigger.
package fir_cap_pkg;

  localparam int FIR_CAP_DW    = 11;
  localparam int FIR_CAP_DEPTH = 64;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/fir_cap_ram.sv
// DEPTH x DW capture buffer: one write port and one synchronous read port.
// The read register only loads when re_i is high, so it holds between reads.
module fir_cap_ram
  import fir_cap_pkg::*;
#(
  parameter int DW    = FIR_CAP_DW,
  parameter int DEPTH = FIR_CAP_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_capture.sv
// Captures a burst of FIR filter output samples into a buffer for later readout.
// Define FIR_CAP_TRIG_EN to add trig_level and start on in_data >= trig_level (signed).
module fir_capture
  import fir_cap_pkg::*;
#(
  parameter  int DW    = FIR_CAP_DW,
  parameter  int DEPTH = FIR_CAP_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          arm,
  input  logic          abort,
`ifdef FIR_CAP_TRIG_EN
  input  logic [DW-1:0] trig_level,
`endif
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [1:0]    state,
  output logic [AW:0]   count,
  output logic          done
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_valid_q;
  logic          rd_zero_q;
  logic          trig_hit;
  logic          rd_accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] ram_rdata;

`ifdef FIR_CAP_TRIG_EN
  assign trig_hit = $signed(in_data) >= $signed(trig_level);
`else
  assign trig_hit = 1'b1;
`endif

  // Reads are only served while the buffer is stable (no capture in flight).
  assign rd_accept = rd_en && (state_q == ST_IDLE || state_q == ST_DONE);

  // abort and arm both win over a same-cycle sample.
  assign wr_en   = in_valid && !abort && !arm &&
                   ((state_q == ST_ARMED && trig_hit) || state_q == ST_CAPTURE);
  assign wr_addr = (state_q == ST_ARMED) ? '0 : count_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_ARMED;
      count_d = '0;
    end else if (wr_en) begin
      count_d = (state_q == ST_ARMED) ? (AW+1)'(1) : count_q + 1'b1;
      state_d = (count_d == CNT_FULL) ? ST_DONE : ST_CAPTURE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_zero_q <= !({1'b0, rd_addr} < count_q);
    end
  end

  fir_cap_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (in_data),
    .re_i    (rd_accept),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // Out-of-range reads and the post-reset value both present zero.
  assign rd_data  = rd_zero_q ? '0 : ram_rdata;
  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign count    = count_q;
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_fir_capture.sv
// Bench for fir_capture: queue-based capture model, read scoreboard and async-reset checks.
// Trigger scenarios are compiled in when FIR_CAP_TRIG_EN is defined.
module tb_fir_capture;
  import fir_cap_pkg::*;

  localparam int DW    = FIR_CAP_DW;
  localparam int DEPTH = FIR_CAP_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          arm;
  logic          abort;
`ifdef FIR_CAP_TRIG_EN
  logic [DW-1:0] trig_level;
`endif
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [1:0]    state;
  logic [AW:0]   count;
  logic          done;

  fir_capture dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .arm        (arm),
    .abort      (abort),
`ifdef FIR_CAP_TRIG_EN
    .trig_level (trig_level),
`endif
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .state      (state),
    .count      (count),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap_q[$];
  int            m_state;
  logic [DW-1:0] last_rd;
  logic [DW-1:0] mon_exp;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_trig(input logic [DW-1:0] d);
`ifdef FIR_CAP_TRIG_EN
    return $signed(d) >= $signed(trig_level);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0;
    cap_q.delete();
    exp_q.delete();
  endtask

  // One clock cycle of stimulus; the model is advanced with the same inputs.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit a, input bit ab,
                      input bit re, input logic [AW-1:0] ra);
    @(negedge clk); #1;
    in_valid = v; in_data = d; arm = a; abort = ab; rd_en = re; rd_addr = ra;
    if (re && (m_state == 0 || m_state == 3))
      exp_q.push_back((int'(ra) < cap_q.size()) ? cap_q[ra] : '0);
    if (ab) begin
      m_state = 0;
    end else if (a) begin
      m_state = 1;
      cap_q.delete();
    end else if (v && ((m_state == 1 && m_trig(d)) || m_state == 2)) begin
      cap_q.push_back(d);
      m_state = (cap_q.size() == DEPTH) ? 3 : 2;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; arm = 1'b0; abort = 1'b0; rd_en = 1'b0;
    check("state", int'(state), m_state);
    check("count", int'(count), cap_q.size());
    check("done", int'(done), int'(m_state == 3));
  endtask

  task automatic sample(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle_cyc();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_arm();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic do_abort();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic rd(input int addr);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(addr));
  endtask

  // Monitor: every rd_valid pops one expected read; a missing or extra response fails.
  always @(negedge clk) begin
    if (rst) begin
      last_rd = '0;
    end else if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_valid_extra: got 1 expected 0 at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", int'(rd_data), int'(mon_exp));
      end
      last_rd = rd_data;
    end else begin
      if (exp_q.size() != 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_valid_missing: got 0 expected 1 at %0t", $time);
        mon_exp = exp_q.pop_front();
      end
      check("rd_data_hold", int'(rd_data), int'(last_rd));
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; arm = 1'b0; abort = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
`ifdef FIR_CAP_TRIG_EN
    trig_level = DW'(-1024);
`endif
    model_reset();
    #1;
    check("rst_state", int'(state), 0);
    check("rst_count", int'(count), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    rd(0);
    idle_cyc();

`ifndef FIR_CAP_TRIG_EN
    // Ramp 0..63 fills the buffer exactly.
    do_arm();
    for (int i = 0; i < DEPTH; i++) sample(DW'(i));
    check("ramp_done_state", int'(state), 3);
    check("ramp_count", int'(count), DEPTH);
    for (int i = 0; i < 4; i++) sample(DW'(500 + i));
    rd(5);
    rd(0);
    rd(63);
    idle_cyc();
`else
    // Level trigger at 10 over 0..99: capture starts at 10, ends at 73.
    trig_level = DW'(10);
    do_arm();
    for (int i = 0; i < 100; i++) begin
      sample(DW'(i));
      if (i < 10) check("armed_wait", int'(state), 1);
    end
    rd(0);
    rd(63);
    rd(30);
    idle_cyc();
    // Negative threshold proves a signed compare.
    trig_level = DW'(-3);
    do_arm();
    sample(DW'(-8));
    sample(DW'(-4));
    check("signed_armed", int'(state), 1);
    sample(DW'(-3));
    check("signed_capture", int'(state), 2);
    sample(DW'(7));
    do_abort();
    rd(0);
    rd(1);
    rd(2);
    idle_cyc();
    trig_level = DW'(-1024);
`endif

    // Abort after 20 samples keeps count and contents.
    do_arm();
    for (int i = 0; i < 20; i++) sample(DW'($urandom_range(0, (1 << DW) - 1)));
    step(1'b1, DW'(77), 1'b1, 1'b1, 1'b0, '0);
    check("abort_state", int'(state), 0);
    check("abort_count", int'(count), 20);
    rd(19);
    rd(20);
    rd(0);
    idle_cyc();

    // Reads during capture are ignored; async reset mid-capture.
    do_arm();
    for (int i = 0; i < 30; i++) begin
      step(1'b1, DW'($urandom_range(0, (1 << DW) - 1)), 1'b0, 1'b0, (i % 3) == 0, AW'(i));
    end
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_count", int'(count), 0);
    check("arst_done", int'(done), 0);
    check("arst_rd_valid", int'(rd_valid), 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    rd(0);
    rd(5);
    idle_cyc();

    // in_valid every other cycle: 64 stored, no gaps or duplicates.
    do_arm();
    for (int i = 0; i < 2 * DEPTH; i++)
      step(i[0] == 1'b0, DW'($urandom_range(0, (1 << DW) - 1)), 1'b0, 1'b0, 1'b0, '0);
    check("toggle_count", int'(count), DEPTH);
    check("toggle_done", int'(done), 1);
    for (int i = 0; i < DEPTH; i++) rd(i);
    idle_cyc();

    // Random traffic against the model.
`ifdef FIR_CAP_TRIG_EN
    trig_level = DW'(int'($urandom_range(0, 200)) - 100);
`endif
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1) == 1,
           DW'($urandom_range(0, (1 << DW) - 1)),
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 2) == 0,
           AW'($urandom_range(0, DEPTH - 1)));
    end
    idle_cyc();
    idle_cyc();

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
